rsa_crt_decrypt: RTL and testbench
==================================

RSA_CRT_DECRYPT -- requirements
Module: rsa_crt_decrypt

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the prime width; the modulus, ciphertext and plaintext are WIDTH*2 bits wide.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start, input, 1 bit: requests a decryption; sampled only in IDLE and DONE.
REQ-005 SHALL have ports p and q, input, WIDTH bits each: the primes, with q^-1 mod p defined.
REQ-006 SHALL have ports dp and dq, input, WIDTH bits each: d mod (p-1) and d mod (q-1).
REQ-007 SHALL have port qinv, input, WIDTH bits: q^-1 mod p.
REQ-008 SHALL have port cipher, input, WIDTH*2 bits: the ciphertext c.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE and DONE.
REQ-010 SHALL have port finish, output, 1 bit: high only in DONE.
REQ-011 SHALL have port err, output, 1 bit: high in DONE when the operand check failed.
REQ-012 SHALL have port msg_out, output, WIDTH*2 bits: the plaintext m; valid while finish is high.

Function
REQ-013 SHALL implement the states IDLE, LOAD, EXP_P, EXP_Q, COMBINE and DONE.
REQ-014 SHALL, in IDLE or DONE with start=1, register p, q, dp, dq, qinv and cipher, clear err, and enter LOAD on the same edge.
REQ-015 SHALL hold its operands internally once registered; input changes while busy is high SHALL have no effect.
REQ-016 SHALL ignore start while busy is high; no queuing and no restart.
REQ-017 SHALL, in LOAD, enter DONE with err=1 and msg_out=0 when p<2 or q<2; otherwise it SHALL register cp = c mod p and cq = c mod q, set the accumulator to 1, and enter EXP_P.
REQ-018 SHALL, in EXP_P, process dp LSB-first, one bit per cycle, for exactly WIDTH cycles, independent of the value of dp.
REQ-019 SHALL perform, in each EXP_P cycle: if the bit is 1, acc = (acc*base) mod p; then base = (base*base) mod p.
REQ-020 SHALL form every product at full 2*WIDTH-bit width before reduction.
REQ-021 SHALL, after EXP_P, store mp = acc and enter EXP_Q.
REQ-022 SHALL, in EXP_Q, perform the same WIDTH-cycle procedure with dq, cq and modulus q, yielding mq.
REQ-023 SHALL, in COMBINE, compute in one cycle t = (mp - (mq mod p)) mod p, adding p when the difference is negative.
REQ-024 SHALL, in the same COMBINE cycle, compute h = (qinv*t) mod p and msg_out = mq + h*q, which fits in WIDTH*2 bits because m < p*q; it SHALL then enter DONE.
REQ-025 SHALL set latency as follows: start sampled at edge k sets finish high after edge k+2*WIDTH+2, i.e. after edge k+66 for WIDTH=32.
REQ-026 SHALL, on the err path, set finish high after edge k+1.
REQ-027 SHALL, in DONE, hold msg_out, finish and err until the next start or reset.
REQ-028 SHALL, on start in DONE, clear finish on the same edge; msg_out keeps its old value until COMBINE overwrites it.
REQ-029 SHALL, on the DONE-to-LOAD restart, produce the same timing as from IDLE.
REQ-030 SHALL produce for dp=0 or dq=0 the partial result 1 mod p or 1 mod q respectively, with no special-casing.
REQ-031 SHALL produce for cipher >= p*q the result (cipher mod p*q)^d mod p*q.
REQ-032 SHALL produce undefined values, but the fixed latency and a return to DONE, when p and q are non-prime or qinv is inconsistent.

Reset
REQ-033 SHALL, with reset=1 at an edge, enter IDLE and set busy=0, finish=0, err=0 and msg_out=0.
REQ-034 SHALL apply REQ-033 in any state, including mid-EXP_P and mid-EXP_Q, and abandon the operation.
REQ-035 SHALL give reset priority over start when both are high at the same edge.

Verification
REQ-036 The bench SHALL cover: p=61, q=53, dp=53, dq=49, qinv=38, cipher=2790, start pulse -> finish after 66 edges, msg_out=65, err=0, busy high for the 66 intervening cycles.
REQ-037 The bench SHALL cover: the same keys with cipher=0 and then cipher=1 -> msg_out=0 and msg_out=1 respectively, with identical latency.
REQ-038 The bench SHALL cover: p=1, q=53, start -> finish after edge k+1, err=1, msg_out=0.
REQ-039 The bench SHALL cover: reset asserted 10 cycles into EXP_P -> next edge busy=0, finish=0, msg_out=0; a subsequent start with cipher=2790 -> 65 after 66 edges.
REQ-040 The bench SHALL cover: start held high continuously -> back-to-back operations, finish high for exactly one cycle per result; start pulses while busy -> ignored, latency unchanged.
REQ-041 The bench SHALL cover: a random sweep over prime pairs below 2^16 compared against a software CRT model, and a check that changing the inputs while busy does not alter msg_out.

Source files
------------

// File: rtl/rsa_crt_decrypt.sv
// RSA decryption by CRT: two bit-serial modular exponentiations
// (mod p, mod q) followed by a single-cycle Garner recombination.
module rsa_crt_decrypt #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   p,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   dp,
  input  logic [WIDTH-1:0]   dq,
  input  logic [WIDTH-1:0]   qinv,
  input  logic [2*WIDTH-1:0] cipher,
  output logic               busy,
  output logic               finish,
  output logic               err,
  output logic [2*WIDTH-1:0] msg_out
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_EXP_P, S_EXP_Q, S_COMBINE, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [WIDTH-1:0] r_p, r_q, r_dp, r_dq, r_qinv;
  logic [DW-1:0]    r_c;
  logic [WIDTH-1:0] r_acc, r_base, r_exp;
  logic [WIDTH-1:0] r_mp, r_mq;
  logic [CW-1:0]    r_cnt;
  logic             r_err;
  logic [DW-1:0]    r_msg;

  logic [WIDTH-1:0] w_mod, w_mul, w_sq, w_acc_nxt;
  logic [WIDTH-1:0] w_cp, w_cq, w_mqp, w_t, w_h;
  logic [DW-1:0]    w_m;
  logic             w_last, w_bad;

  assign w_mod = (r_state == S_EXP_Q) ? r_q : r_p;
  assign w_mul = WIDTH'((DW'(r_acc) * DW'(r_base)) % DW'(w_mod));
  assign w_sq  = WIDTH'((DW'(r_base) * DW'(r_base)) % DW'(w_mod));
  assign w_acc_nxt = r_exp[0] ? w_mul : r_acc;
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  assign w_bad = (r_p < WIDTH'(2)) || (r_q < WIDTH'(2));
  assign w_cp  = WIDTH'(r_c % DW'(r_p));
  assign w_cq  = WIDTH'(r_c % DW'(r_q));

  // Garner: t wraps in WIDTH bits, so adding p after a borrow is exact
  assign w_mqp = WIDTH'(DW'(r_mq) % DW'(r_p));
  assign w_t   = r_mp - w_mqp + ((r_mp < w_mqp) ? r_p : '0);
  assign w_h   = WIDTH'((DW'(r_qinv) * DW'(w_t)) % DW'(r_p));
  assign w_m   = DW'(r_mq) + DW'(w_h) * DW'(r_q);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_LOAD;
      S_LOAD:         w_next = w_bad ? S_DONE : S_EXP_P;
      S_EXP_P:        if (w_last) w_next = S_EXP_Q;
      S_EXP_Q:        if (w_last) w_next = S_COMBINE;
      S_COMBINE:      w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE, S_DONE: if (start) begin
        r_p    <= p;
        r_q    <= q;
        r_dp   <= dp;
        r_dq   <= dq;
        r_qinv <= qinv;
        r_c    <= cipher;
      end
      S_LOAD: begin
        r_acc  <= WIDTH'(1);
        r_base <= w_cp;
        r_exp  <= r_dp;
        r_cnt  <= '0;
      end
      S_EXP_P, S_EXP_Q: begin
        r_acc  <= w_acc_nxt;
        r_base <= w_sq;
        r_exp  <= r_exp >> 1;
        r_cnt  <= r_cnt + CW'(1);
        if (w_last && r_state == S_EXP_P) begin
          r_mp   <= w_acc_nxt;
          r_acc  <= WIDTH'(1);
          r_base <= w_cq;
          r_exp  <= r_dq;
          r_cnt  <= '0;
        end else if (w_last) begin
          r_mq   <= w_acc_nxt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
      r_msg <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) r_err <= 1'b0;
        S_LOAD: if (w_bad) begin
          r_err <= 1'b1;
          r_msg <= '0;
        end
        S_COMBINE: r_msg <= w_m;
        default: ;
      endcase
    end
  end

  assign busy    = !(r_state == S_IDLE || r_state == S_DONE);
  assign finish  = (r_state == S_DONE);
  assign err     = r_err;
  assign msg_out = r_msg;

endmodule

// File: tb/tb_rsa_crt_decrypt.sv
// Bench for rsa_crt_decrypt: vector table, reset/back-to-back sequences
// and a random sweep checked against a direct c^d mod (p*q) model.
module tb_rsa_crt_decrypt;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] p, q, dp, dq, qinv;
  logic [63:0] cipher;
  logic        busy, finish, err;
  logic [63:0] msg_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rsa_crt_decrypt dut (
    .clk(clk), .reset(reset), .start(start),
    .p(p), .q(q), .dp(dp), .dq(dq), .qinv(qinv),
    .cipher(cipher), .busy(busy), .finish(finish),
    .err(err), .msg_out(msg_out)
  );

  typedef struct {
    logic [31:0] p, q, dp, dq, qi;
    logic [63:0] c, m;
    logic        e;
    int          lat;
  } vec_t;

  vec_t tbl[8];

  function automatic bit [63:0] powmod(bit [63:0] b, bit [63:0] e, bit [63:0] m);
    bit [63:0] r;
    r = 64'd1 % m;
    b = b % m;
    while (e != 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic bit is_prime(bit [63:0] n);
    if (n < 2) return 1'b0;
    for (bit [63:0] i = 2; i * i <= n; i++)
      if (n % i == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit [63:0] rand_prime();
    bit [63:0] x;
    do x = 64'($urandom_range(3, 65535)); while (!is_prime(x));
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic run(input logic [31:0] tp, tq, tdp, tdq, tqi,
                     input logic [63:0] tc, input bit noise,
                     output int lat, output int bz);
    @(negedge clk);
    p = tp; q = tq; dp = tdp; dq = tdq; qinv = tqi; cipher = tc;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bz = 0;
    while (!finish && lat < 200) begin
      if (!busy) bz++;
      if (noise) begin
        p = $urandom; q = $urandom; dp = $urandom; dq = $urandom;
        qinv = $urandom; cipher = {$urandom, $urandom};
        start = 1'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (busy) bz++;
  endtask

  task automatic reset_mid(input int n, input string nm);
    @(negedge clk);
    p = 61; q = 53; dp = 53; dq = 49; qinv = 38; cipher = 2790;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk({nm, " busy before"}, 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk({nm, " busy"}, 64'(busy), 64'd0);
    chk({nm, " finish"}, 64'(finish), 64'd0);
    chk({nm, " err"}, 64'(err), 64'd0);
    chk({nm, " msg"}, msg_out, 64'd0);
  endtask

  initial begin
    int lat, bz, g, n;
    bit [63:0] a, b, nn, d, c, ex;

    tbl[0] = '{61, 53, 53, 49, 38, 2790, 65, 1'b0, 66};
    tbl[1] = '{61, 53, 53, 49, 38, 0, 0, 1'b0, 66};
    tbl[2] = '{61, 53, 53, 49, 38, 1, 1, 1'b0, 66};
    tbl[3] = '{1, 53, 53, 49, 38, 2790, 0, 1'b1, 1};
    tbl[4] = '{61, 53, 53, 49, 38, 6023, 65, 1'b0, 66};
    tbl[5] = '{61, 53, 0, 0, 38, 2790, 1, 1'b0, 66};
    tbl[6] = '{61, 0, 53, 49, 38, 2790, 0, 1'b1, 1};
    tbl[7] = '{61, 53, 53, 49, 38, 64'hFFFF_FFFF_FFFF_FFFF,
               powmod(64'hFFFF_FFFF_FFFF_FFFF, 2753, 3233), 1'b0, 66};

    reset = 1'b1; start = 1'b0;
    p = '0; q = '0; dp = '0; dq = '0; qinv = '0; cipher = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst finish", 64'(finish), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst msg", msg_out, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run(tbl[i].p, tbl[i].q, tbl[i].dp, tbl[i].dq, tbl[i].qi,
          tbl[i].c, 1'b0, lat, bz);
      chk($sformatf("vec%0d lat", i), 64'(lat), 64'(tbl[i].lat));
      chk($sformatf("vec%0d msg", i), msg_out, tbl[i].m);
      chk($sformatf("vec%0d err", i), 64'(err), 64'(tbl[i].e));
      chk($sformatf("vec%0d busy", i), 64'(bz), 64'd0);
    end

    run(61, 53, 53, 49, 38, 2790, 1'b0, lat, bz);
    reset_mid(11, "rst_expp");
    run(61, 53, 53, 49, 38, 2790, 1'b0, lat, bz);
    chk("after rst_expp lat", 64'(lat), 64'd66);
    chk("after rst_expp msg", msg_out, 64'd65);
    reset_mid(45, "rst_expq");
    run(61, 53, 53, 49, 38, 2790, 1'b0, lat, bz);
    chk("after rst_expq msg", msg_out, 64'd65);

    run(1, 53, 53, 49, 38, 2790, 1'b0, lat, bz);
    chk("pre prio err", 64'(err), 64'd1);
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("prio busy", 64'(busy), 64'd0);
    chk("prio finish", 64'(finish), 64'd0);
    chk("prio err", 64'(err), 64'd0);

    @(negedge clk);
    p = 61; q = 53; dp = 53; dq = 49; qinv = 38; cipher = 2790;
    start = 1'b1;
    n = 0;
    while (!finish && n < 300) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("b2b first lat", 64'(n), 64'd67);
    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      @(negedge clk);
      chk("b2b finish pulse", 64'(finish), 64'd0);
      g = 1;
      while (!finish && g < 300) begin
        @(posedge clk);
        @(negedge clk);
        g++;
      end
      chk("b2b gap", 64'(g), 64'd67);
      chk("b2b msg", msg_out, 64'd65);
    end
    start = 1'b0;

    for (int it = 0; it < 16; it++) begin
      a = rand_prime();
      do b = rand_prime(); while (b == a);
      nn = a * b;
      d = 64'($urandom);
      if (d == 0) d = 1;
      c = {$urandom, $urandom};
      ex = powmod(c % nn, d, nn);
      run(32'(a), 32'(b), 32'(((d - 1) % (a - 1)) + 1),
          32'(((d - 1) % (b - 1)) + 1), 32'(powmod(b % a, a - 2, a)),
          c, it[0], lat, bz);
      chk($sformatf("rnd%0d lat p=%0d q=%0d", it, a, b), 64'(lat), 64'd66);
      chk($sformatf("rnd%0d msg p=%0d q=%0d", it, a, b), msg_out, ex);
      chk($sformatf("rnd%0d err", it), 64'(err), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
